id_exe_stage_reg: RTL and testbench

ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

---
 rtl/id_exe_stage_reg_pkg.sv | 12 +
 rtl/id_exe_stage_reg_pipe_reg.sv | 42 ++++
 rtl/id_exe_stage_reg.sv | 118 +++++++++++
 tb/tb_id_exe_stage_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared constants for the ID/EXE pipeline boundary.
// Field widths used by the decode and execute stages of the pipeline.
package id_exe_stage_reg_pkg;

  localparam int WORD_LEN                  = 32;
  localparam int REGISTER_FILE_ADDRESS_LEN = 4;
  localparam int EXECUTE_COMMAND_LEN       = 4;
  localparam int SHIFTER_OPERAND_LEN       = 12;
  localparam int SIGNED_IMM_LEN            = 24;
  localparam int STATUS_REG_LEN            = 4;

endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// pipe_reg: generic pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears q to 0
//   ld   - load enable; when low (and clr low) q holds
//   clr  - synchronous clear to 0, takes priority over ld
//   d    - next value
//   q    - registered value
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: pipeline register between decode and execute.
// Ports:
//   clk, rst       - clock and synchronous active-high reset (all outputs -> 0)
//   freeze         - memory stall: hold every output
//   flush          - taken branch: load a bubble (control, tags, exe_cmd -> 0)
//   *_in / *_out   - decoded instruction fields, registered with 1-cycle latency
// Priority per edge: rst > freeze > flush > normal load.
// The fields are split into three pipe_reg groups that differ only in
// when they are cleared:
//   data    - never cleared except by rst (payload is don't-care in a bubble)
//   tag     - valid, exe_cmd, dest, src1, src2: cleared on flush
//   control - write/branch/status enables: cleared on flush or valid_in=0,
//             so a non-valid slot can never write downstream
module id_exe_stage_reg #(
  parameter int WORD_LEN     = id_exe_stage_reg_pkg::WORD_LEN,
  parameter int REG_ADDR_LEN = id_exe_stage_reg_pkg::REGISTER_FILE_ADDRESS_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    freeze,
  input  logic [WORD_LEN-1:0]     pc_in,
  input  logic [WORD_LEN-1:0]     val_rn_in,
  input  logic [WORD_LEN-1:0]     val_rm_in,
  input  logic [3:0]              exe_cmd_in,
  input  logic [11:0]             shift_operand_in,
  input  logic [23:0]             signed_imm_24_in,
  input  logic [3:0]              status_in,
  input  logic                    wb_en_in,
  input  logic                    mem_r_en_in,
  input  logic                    mem_w_en_in,
  input  logic                    b_in,
  input  logic                    s_in,
  input  logic                    imm_in,
  input  logic                    valid_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [REG_ADDR_LEN-1:0] src1_in,
  input  logic [REG_ADDR_LEN-1:0] src2_in,
  output logic [WORD_LEN-1:0]     pc_out,
  output logic [WORD_LEN-1:0]     val_rn_out,
  output logic [WORD_LEN-1:0]     val_rm_out,
  output logic [3:0]              exe_cmd_out,
  output logic [11:0]             shift_operand_out,
  output logic [23:0]             signed_imm_24_out,
  output logic [3:0]              status_out,
  output logic                    wb_en_out,
  output logic                    mem_r_en_out,
  output logic                    mem_w_en_out,
  output logic                    b_out,
  output logic                    s_out,
  output logic                    imm_out,
  output logic                    valid_out,
  output logic [REG_ADDR_LEN-1:0] dest_out,
  output logic [REG_ADDR_LEN-1:0] src1_out,
  output logic [REG_ADDR_LEN-1:0] src2_out
);
  import id_exe_stage_reg_pkg::*;

  localparam int DATA_W = 3 * WORD_LEN + SHIFTER_OPERAND_LEN + SIGNED_IMM_LEN
                          + 1 + STATUS_REG_LEN;
  localparam int TAG_W  = 1 + EXECUTE_COMMAND_LEN + 3 * REG_ADDR_LEN;
  localparam int CTRL_W = 5;

  logic              ld;
  logic              tag_clr;
  logic              ctrl_clr;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_d;
  logic [TAG_W-1:0]  tag_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;

  // Clears are gated by ~freeze so a flush arriving during a stall is
  // dropped; the branch stage is stalled too and re-issues it afterwards.
  always_comb begin
    ld       = ~freeze;
    tag_clr  = flush & ~freeze;
    ctrl_clr = (flush | ~valid_in) & ~freeze;
    data_d   = {pc_in, val_rn_in, val_rm_in, shift_operand_in,
                signed_imm_24_in, imm_in, status_in};
    tag_d    = {valid_in, exe_cmd_in, dest_in, src1_in, src2_in};
    ctrl_d   = {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in};
  end

  pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .clr (1'b0),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_reg #(.WIDTH(TAG_W)) u_tag_reg (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .clr (tag_clr),
    .d   (tag_d),
    .q   (tag_q)
  );

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .clr (ctrl_clr),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  assign {pc_out, val_rn_out, val_rm_out, shift_operand_out,
          signed_imm_24_out, imm_out, status_out} = data_q;
  assign {valid_out, exe_cmd_out, dest_out, src1_out, src2_out} = tag_q;
  assign {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out} = ctrl_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  cmd;
    logic [11:0] sh;
    logic [23:0] imm24;
    logic [3:0]  st;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic        imm;
    logic        valid;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
  } fields_t;

  logic    clk;
  logic    rst;
  logic    flush;
  logic    freeze;
  fields_t in_f;
  fields_t exp_f;
  int      total;
  int      bad;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  exe_cmd_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
  logic [3:0]  dest_out, src1_out, src2_out;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_exe_stage_reg #(.WORD_LEN(32), .REG_ADDR_LEN(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .freeze            (freeze),
    .pc_in             (in_f.pc),
    .val_rn_in         (in_f.rn),
    .val_rm_in         (in_f.rm),
    .exe_cmd_in        (in_f.cmd),
    .shift_operand_in  (in_f.sh),
    .signed_imm_24_in  (in_f.imm24),
    .status_in         (in_f.st),
    .wb_en_in          (in_f.wb),
    .mem_r_en_in       (in_f.mr),
    .mem_w_en_in       (in_f.mw),
    .b_in              (in_f.b),
    .s_in              (in_f.s),
    .imm_in            (in_f.imm),
    .valid_in          (in_f.valid),
    .dest_in           (in_f.dest),
    .src1_in           (in_f.s1),
    .src2_in           (in_f.s2),
    .pc_out            (pc_out),
    .val_rn_out        (val_rn_out),
    .val_rm_out        (val_rm_out),
    .exe_cmd_out       (exe_cmd_out),
    .shift_operand_out (shift_operand_out),
    .signed_imm_24_out (signed_imm_24_out),
    .status_out        (status_out),
    .wb_en_out         (wb_en_out),
    .mem_r_en_out      (mem_r_en_out),
    .mem_w_en_out      (mem_w_en_out),
    .b_out             (b_out),
    .s_out             (s_out),
    .imm_out           (imm_out),
    .valid_out         (valid_out),
    .dest_out          (dest_out),
    .src1_out          (src1_out),
    .src2_out          (src2_out)
  );

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one rising edge, from the stage's rules.
  function automatic fields_t model_edge(input fields_t cur, input fields_t nxt_in,
                                         input logic r, input logic fz, input logic fl);
    fields_t o;
    o = cur;
    if (r) begin
      o = '{default: '0};
    end else if (fz) begin
      o = cur;
    end else begin
      o = nxt_in;
      if (fl || !nxt_in.valid) begin
        o.wb = 0; o.mr = 0; o.mw = 0; o.b = 0; o.s = 0;
      end
      if (fl) begin
        o.valid = 0; o.dest = 0; o.s1 = 0; o.s2 = 0; o.cmd = 0;
      end
    end
    return o;
  endfunction

  task automatic check_all();
    check("pc", pc_out, exp_f.pc);
    check("val_rn", val_rn_out, exp_f.rn);
    check("val_rm", val_rm_out, exp_f.rm);
    check("exe_cmd", {28'd0, exe_cmd_out}, {28'd0, exp_f.cmd});
    check("shift_operand", {20'd0, shift_operand_out}, {20'd0, exp_f.sh});
    check("signed_imm_24", {8'd0, signed_imm_24_out}, {8'd0, exp_f.imm24});
    check("status", {28'd0, status_out}, {28'd0, exp_f.st});
    check("ctrl_bits", {25'd0, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out},
          {25'd0, exp_f.wb, exp_f.mr, exp_f.mw, exp_f.b, exp_f.s, exp_f.imm, exp_f.valid});
    check("dest", {28'd0, dest_out}, {28'd0, exp_f.dest});
    check("src1", {28'd0, src1_out}, {28'd0, exp_f.s1});
    check("src2", {28'd0, src2_out}, {28'd0, exp_f.s2});
    // a non-valid slot must never carry a write enable
    check("bubble_no_write", {31'd0, (~valid_out) & (wb_en_out | mem_w_en_out)}, 32'd0);
  endtask

  // driver: advance one edge, update model, compare everything
  task automatic step();
    @(posedge clk);
    exp_f = model_edge(exp_f, in_f, rst, freeze, flush);
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    in_f.pc    = $urandom;
    in_f.rn    = $urandom;
    in_f.rm    = $urandom;
    in_f.cmd   = 4'($urandom_range(0, 15));
    in_f.sh    = 12'($urandom_range(0, 4095));
    in_f.imm24 = 24'($urandom_range(0, 24'hFFFFFF));
    in_f.st    = 4'($urandom_range(0, 15));
    in_f.wb    = 1'($urandom_range(0, 1));
    in_f.mr    = 1'($urandom_range(0, 1));
    in_f.mw    = 1'($urandom_range(0, 1));
    in_f.b     = 1'($urandom_range(0, 1));
    in_f.s     = 1'($urandom_range(0, 1));
    in_f.imm   = 1'($urandom_range(0, 1));
    in_f.valid = ($urandom_range(0, 3) != 0);
    in_f.dest  = 4'($urandom_range(0, 15));
    in_f.s1    = 4'($urandom_range(0, 15));
    in_f.s2    = 4'($urandom_range(0, 15));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    exp_f  = '{default: '0};
    rst    = 1'b1;
    flush  = 1'b0;
    freeze = 1'b0;
    rand_inputs();

    // reset state
    step();
    step();
    rst = 1'b0;

    // plain load
    rand_inputs();
    in_f.pc = 32'h10; in_f.dest = 4'd3; in_f.wb = 1'b1; in_f.valid = 1'b1;
    step();
    check("load_pc", pc_out, 32'h10);
    check("load_wb", {31'd0, wb_en_out}, 32'd1);

    // freeze holds for exactly 3 edges, then resumes
    in_f.rn = 32'hAAAA5555; in_f.valid = 1'b1;
    step();
    in_f.rn = 32'h1;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze_hold_rn", val_rn_out, 32'hAAAA5555);
    end
    freeze = 1'b0;
    step();
    check("freeze_release_rn", val_rn_out, 32'h1);

    // flush bubble
    in_f.mw = 1'b1; in_f.s1 = 4'd5; in_f.valid = 1'b1;
    flush = 1'b1;
    step();
    check("flush_mw", {31'd0, mem_w_en_out}, 32'd0);
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    step();  // back-to-back bubble
    flush = 1'b0;

    // freeze wins over flush
    in_f.wb = 1'b1; in_f.dest = 4'd7; in_f.valid = 1'b1;
    step();
    freeze = 1'b1; flush = 1'b1;
    rand_inputs();
    step();
    check("freeze_flush_dest", {28'd0, dest_out}, 32'd7);
    check("freeze_flush_wb", {31'd0, wb_en_out}, 32'd1);

    // reset during freeze, then load
    rst = 1'b1; flush = 1'b0;
    step();
    check("rst_in_freeze_pc", pc_out, 32'd0);
    rst = 1'b0; freeze = 1'b0;
    in_f.pc = 32'h20;
    step();
    check("after_rst_pc", pc_out, 32'h20);

    // invalid input kills control bits
    in_f.valid = 1'b0; in_f.wb = 1'b1; in_f.b = 1'b1;
    step();
    check("invalid_wb_b", {30'd0, wb_en_out, b_out}, 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      rst    = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
